// File: rtl/weight_pingpong_buf.sv
// Two-bank ping-pong store for per-output-channel weights.
// Ports:
//   weight_* : write side (addr/data/strobe, done = channel complete)
//   wr_full  : both banks hold unread channels
//   rd_*     : 1-cycle-latency random-access read side, release frees bank
//   err      : sticky protocol / address error
module weight_pingpong_buf #(
  parameter int W3_WORDS = 72,
  parameter int W1_WORDS = 8,
  parameter int DW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   weight_waddr,
  input  logic [DW-1:0] weight_wdata,
  input  logic          weight_wen,
  input  logic          weight_done,
  output logic          wr_full,
  output logic          rd_rdy,
  output logic [7:0]    rd_out_ch,
  input  logic          rd_en,
  input  logic [6:0]    rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_data_vld,
  input  logic          rd_release,
  output logic          err
);

  localparam int NW = W3_WORDS + W1_WORDS;
  localparam int AW = 7;
  localparam logic [AW-1:0] W3_L = AW'(W3_WORDS);
  localparam logic [AW-1:0] W1_L = AW'(W1_WORDS);
  localparam logic [AW-1:0] NW_L = AW'(NW);

  logic [DW-1:0] bank0 [NW];
  logic [DW-1:0] bank1 [NW];

  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      full;
  logic [1:0]      full_nxt;
  logic [AW-1:0]   wr_cnt;
  logic [1:0][7:0] tag;

  logic [AW-1:0] idx;
  logic          off_ok;
  logic [AW-1:0] w_word;
  logic          w_legal;
  logic          wr_ok;
  logic          wr_bad;
  logic [AW-1:0] cnt_inc;
  logic [AW-1:0] cnt_eff;
  logic          commit;
  logic          done_bad;
  logic          rd_ok;
  logic          rd_bad;
  logic          rel_ok;
  logic          rel_bad;
  logic [DW-1:0] rd_word;

  assign idx    = weight_waddr[8:2];
  assign off_ok = (weight_waddr[22:9] == 14'd0);

  // 1x1 weights live after the 3x3 block in the same bank
  always_comb begin
    w_word  = idx;
    w_legal = 1'b0;
    if (weight_waddr[31]) begin
      w_word  = idx + W3_L;
      w_legal = off_ok && (idx < W1_L);
    end else begin
      w_legal = off_ok && (idx < W3_L);
    end
  end

  assign wr_ok  = weight_wen & w_legal & ~full[wr_ptr];
  assign wr_bad = weight_wen & ~wr_ok;

  assign cnt_inc = (wr_cnt == NW_L) ? wr_cnt : wr_cnt + 7'd1;
  // a write in the done cycle still counts toward the bank it lands in
  assign cnt_eff = wr_ok ? cnt_inc : wr_cnt;

  assign commit   = weight_done & ~full[wr_ptr];
  assign done_bad = weight_done & (full[wr_ptr] | (cnt_eff != NW_L));

  assign rd_ok   = rd_en & full[rd_ptr] & (rd_addr < NW_L);
  assign rd_bad  = rd_en & ~rd_ok;
  assign rel_ok  = rd_release & full[rd_ptr];
  assign rel_bad = rd_release & ~full[rd_ptr];

  // commit needs an empty bank, release a full one, so they never collide
  always_comb begin
    full_nxt = full;
    if (commit) full_nxt[wr_ptr] = 1'b1;
    if (rel_ok) full_nxt[rd_ptr] = 1'b0;
  end

  assign rd_word   = rd_ptr ? bank1[rd_addr] : bank0[rd_addr];
  assign rd_rdy    = full[rd_ptr];
  assign rd_out_ch = tag[rd_ptr];
  assign wr_full   = full[0] & full[1];

  // storage is not reset
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      if (wr_ptr) bank1[w_word] <= weight_wdata;
      else        bank0[w_word] <= weight_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      full        <= 2'b00;
      wr_cnt      <= '0;
      tag         <= '0;
      rd_data     <= '0;
      rd_data_vld <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_cnt      <= cnt_inc;
        tag[wr_ptr] <= weight_waddr[30:23];
      end
      if (commit) begin
        wr_ptr <= ~wr_ptr;
        wr_cnt <= '0;
      end
      if (rel_ok) rd_ptr <= ~rd_ptr;
      full        <= full_nxt;
      rd_data_vld <= rd_ok;
      if (rd_ok) rd_data <= rd_word;
      if (wr_bad | done_bad | rd_bad | rel_bad) err <= 1'b1;
    end
  end

endmodule

// File: doc/weight_pingpong_buf.md
Name: weight_pingpong_buf

Overview:
- Receives the per-output-channel weight stream from the weight bus interface unit.
- Inputs are weight_waddr, weight_wdata, weight_wen and weight_done.
- Stores the weights in two ping-pong banks of 80 words each: 72 words of 3x3 weights, then 8 words of 1x1 weights.
- Serves random-access, 1-cycle-latency reads to the MAC array, so the next output channel can be fetched while the current one is consumed.

Parameters:
- W3_WORDS, 72, number of 3x3 weight words per output channel.
- W1_WORDS, 8, number of 1x1 weight words per output channel.
- DW, 32, weight word width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- weight_waddr  in  32  bit31: 0 = 3x3, 1 = 1x1. [30:23]: out_ch_cnt. [22:0]: byte offset within the region.
- weight_wdata  in  DW  write data.
- weight_wen  in  1  write strobe, one word per cycle.
- weight_done  in  1  1-cycle pulse: the current channel fetch is complete.
- wr_full  out  1  both banks full; the controller must not issue weight_start.
- rd_rdy  out  1  the read bank holds a complete channel.
- rd_out_ch  out  8  out_ch_cnt tag of the read bank.
- rd_en  in  1  read request.
- rd_addr  in  7  word index: 0..71 = 3x3, 72..79 = 1x1.
- rd_data  out  DW  read data.
- rd_data_vld  out  1  rd_data valid.
- rd_release  in  1  1-cycle pulse: MAC has finished with the read bank.
- err  out  1  sticky error flag.

Behaviour:
- Reset (synchronous, active-high, priority over all other inputs, also mid-operation):
  - wr_ptr = 0, rd_ptr = 0, full[1:0] = 0, wr_cnt = 0.
  - Outputs: rd_rdy = 0, rd_out_ch = 0, rd_data = 0, rd_data_vld = 0, err = 0, wr_full = 0.
  - Bank contents are not cleared.
- Address map:
  - idx = weight_waddr[8:2]. Offset bits [22:9] must be 0 and bits [1:0] are ignored.
  - bit31 = 0: word = idx, legal when idx < 72.
  - bit31 = 1: word = 72 + idx, legal when idx < 8.
- Write, on weight_wen:
  - If full[wr_ptr] = 1 or the address is illegal: write dropped, err <= 1.
  - Otherwise: bank[wr_ptr][word] <= wdata, wr_cnt <= wr_cnt + 1 (saturating at 80), tag[wr_ptr] <= weight_waddr[30:23].
- Commit, on weight_done with full[wr_ptr] = 0:
  - full[wr_ptr] <= 1, wr_ptr toggles, wr_cnt <= 0.
  - If the write count (including a same-cycle weight_wen) is not 80: err <= 1, and the bank is still committed.
  - weight_done with full[wr_ptr] = 1: ignored, err <= 1.
  - weight_wen and weight_done in the same cycle: the write lands in the old bank before the commit.
- Read:
  - rd_rdy = full[rd_ptr]; rd_out_ch = tag[rd_ptr]; both combinational from registers.
  - rd_en with rd_rdy = 1 and rd_addr < 80: next cycle rd_data = bank[rd_ptr][rd_addr], rd_data_vld = 1.
  - rd_en with rd_rdy = 0 or rd_addr >= 80: next cycle rd_data_vld = 0, rd_data holds its value, err <= 1.
  - Back-to-back reads are allowed, one per cycle.
- Release:
  - rd_release with rd_rdy = 1: full[rd_ptr] <= 0, rd_ptr toggles.
  - rd_release with rd_rdy = 0: ignored, err <= 1.
  - rd_en in the release cycle still reads the old bank.
- wr_full = full[0] & full[1].
- Commit and release in the same cycle are both applied; they always act on different banks because wr_ptr and rd_ptr select them.
- Ordering is strictly FIFO: channels are read in commit order.
- err is cleared only by rst.
- State per bank: EMPTY -> FILLING (first legal write) -> FULL (weight_done) -> EMPTY (rd_release). wr_ptr/rd_ptr alternate 0,1,0,...

Test Plan:
- Fill channel 5: 72 writes (bit31 = 0, offsets 0x0..0x11C, data = 0x1000 + i), then 8 writes (bit31 = 1, offsets 0x0..0x1C, data = 0x2000 + i), then weight_done.
  - Next cycle: rd_rdy = 1, rd_out_ch = 5.
  - Read addr 0 -> 0x1000; addr 71 -> 0x1047; addr 72 -> 0x2000; addr 79 -> 0x2007, each one cycle later with rd_data_vld = 1. err = 0.
- Ping-pong: fill channel 1, fill channel 2 -> wr_full = 1.
  - Third-channel writes are dropped and err = 1.
  - Release -> rd_out_ch = 2, wr_full = 0.
- Concurrent: commit channel 3 into bank 1 and rd_release of bank 0 in the same cycle.
  - Next cycle: rd_rdy = 1, rd_out_ch = 3.
  - Channel 4 writes go to bank 0 correctly.
- Illegal accesses, each case from reset:
  - write with bit31 = 1 and offset 0x20 -> dropped, err = 1;
  - rd_en while rd_rdy = 0 -> rd_data_vld = 0, err = 1;
  - weight_done after only 79 writes -> bank committed, err = 1.
- Reset mid-fill after 40 writes: assert rst for 1 cycle.
  - All flags clear; a following complete fill commits to bank 0 with err = 0.
- weight_wen and weight_done in the same cycle on word 79 (0xDEAD) -> committed; reading addr 79 returns 0xDEAD.
